// File: rtl/motor_cmd_dispatcher.sv
// Motor command dispatcher: assembles 5-byte UART frames and hands each command
// to one of NUM_CH step/dir channels through a one-deep pending slot.
module motor_cmd_dispatcher #(
  parameter int NUM_CH      = 10,
  parameter int TIMEOUT_CYC = 2400000,
  parameter int START_WAIT  = 16
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic [NUM_CH-1:0]    ch_active,
  output logic [15*NUM_CH-1:0] ch_divider,
  output logic [15*NUM_CH-1:0] ch_steps,
  output logic [NUM_CH-1:0]    ch_dir,
  output logic [NUM_CH-1:0]    ch_load,
  output logic [NUM_CH-1:0]    pending,
  output logic                 frame_err,
  output logic                 frame_drop,
  output logic                 rx_timeout,
  output logic                 start_fail
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int WW = $clog2(START_WAIT + 1);
  localparam logic [4:0] NUM_CH_V = 5'(NUM_CH);

  typedef enum logic [1:0] {IDLE, LOADED, RUNNING} chState_t;

  logic [39:0]       shiftReg;
  logic [2:0]        byteCnt;
  logic [TW-1:0]     toCnt;
  logic              frameReady;
  logic [NUM_CH-1:0] activeQ;
  logic [NUM_CH-1:0] failVec;
  logic [NUM_CH-1:0] dropVec;

  logic [3:0]  frmCh;
  logic [14:0] frmDiv;
  logic [14:0] frmSteps;
  logic        frmDir;
  logic        chInRange;

  assign frmCh     = shiftReg[3:0];
  assign frmDiv    = shiftReg[18:4];
  assign frmSteps  = shiftReg[33:19];
  assign frmDir    = shiftReg[34];
  assign chInRange = ({1'b0, frmCh} < NUM_CH_V);

  // A byte arriving in the expiry cycle wins over the timeout.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      shiftReg   <= '0;
      byteCnt    <= '0;
      toCnt      <= '0;
      frameReady <= 1'b0;
      rx_timeout <= 1'b0;
    end else begin
      frameReady <= 1'b0;
      rx_timeout <= 1'b0;
      if (rx_valid) begin
        shiftReg <= {rx_data, shiftReg[39:8]};
        toCnt    <= TW'(TIMEOUT_CYC);
        if (byteCnt == 3'd4) begin
          byteCnt    <= '0;
          frameReady <= 1'b1;
        end else begin
          byteCnt <= byteCnt + 3'd1;
        end
      end else if (toCnt != '0) begin
        toCnt <= toCnt - 1'b1;
        if (toCnt == TW'(1) && byteCnt != '0) begin
          byteCnt    <= '0;
          rx_timeout <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      frame_err  <= 1'b0;
      frame_drop <= 1'b0;
      start_fail <= 1'b0;
      activeQ    <= '0;
    end else begin
      frame_err  <= frameReady && !chInRange;
      frame_drop <= |dropVec;
      start_fail <= |failVec;
      activeQ    <= ch_active;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    chState_t      st, stNext;
    logic [WW-1:0] waitCnt, waitNext;
    logic          hit, done, accept, failC, dropC;
    logic [14:0]   divR, stepsR;
    logic          dirR, loadR;

    assign hit  = frameReady && chInRange && (frmCh == 4'(c));
    assign done = (st == RUNNING) && !activeQ[c];

    // Completion is resolved before the frame so a finishing channel can accept.
    always_comb begin
      stNext   = st;
      waitNext = waitCnt;
      accept   = 1'b0;
      failC    = 1'b0;
      dropC    = 1'b0;
      unique case (st)
        LOADED: begin
          if (activeQ[c]) begin
            stNext = RUNNING;
          end else if (waitCnt == WW'(START_WAIT - 1)) begin
            stNext = IDLE;
            failC  = 1'b1;
          end else begin
            waitNext = waitCnt + 1'b1;
          end
        end
        RUNNING: if (!activeQ[c]) stNext = IDLE;
        default: ;
      endcase
      if (hit) begin
        if (st == IDLE || done) begin
          accept   = 1'b1;
          stNext   = (frmSteps != '0) ? LOADED : IDLE;
          waitNext = '0;
        end else begin
          dropC = 1'b1;
        end
      end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
        st      <= IDLE;
        waitCnt <= '0;
        divR    <= '0;
        stepsR  <= '0;
        dirR    <= 1'b0;
        loadR   <= 1'b0;
      end else begin
        st      <= stNext;
        waitCnt <= waitNext;
        loadR   <= accept;
        if (accept) begin
          divR   <= frmDiv;
          stepsR <= frmSteps;
          dirR   <= frmDir;
        end else if (done) begin
          stepsR <= '0;
        end
      end
    end

    assign failVec[c]            = failC;
    assign dropVec[c]            = dropC;
    assign ch_divider[15*c +: 15] = divR;
    assign ch_steps[15*c +: 15]   = stepsR;
    assign ch_dir[c]              = dirR;
    assign ch_load[c]             = loadR;
    assign pending[c]             = (st != IDLE);
  end

endmodule

// File: tb/tb_motor_cmd_dispatcher.sv
// Bench for motor_cmd_dispatcher: directed scenarios plus randomized frames,
// checked against a per-channel behavioural model of command slots.
module tb_motor_cmd_dispatcher;
  localparam int NUM_CH      = 10;
  localparam int TIMEOUT_CYC = 100;
  localparam int START_WAIT  = 16;

  logic                 CLK = 1'b0;
  logic                 rst_n;
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic [NUM_CH-1:0]    ch_active;
  logic [15*NUM_CH-1:0] ch_divider;
  logic [15*NUM_CH-1:0] ch_steps;
  logic [NUM_CH-1:0]    ch_dir;
  logic [NUM_CH-1:0]    ch_load;
  logic [NUM_CH-1:0]    pending;
  logic                 frame_err;
  logic                 frame_drop;
  logic                 rx_timeout;
  logic                 start_fail;

  always #5 CLK = ~CLK;

  motor_cmd_dispatcher #(
    .NUM_CH(NUM_CH),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .START_WAIT(START_WAIT)
  ) dut (
    .CLK(CLK),
    .rst_n(rst_n),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .ch_active(ch_active),
    .ch_divider(ch_divider),
    .ch_steps(ch_steps),
    .ch_dir(ch_dir),
    .ch_load(ch_load),
    .pending(pending),
    .frame_err(frame_err),
    .frame_drop(frame_drop),
    .rx_timeout(rx_timeout),
    .start_fail(start_fail)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Model: what each channel's command slot should hold, plus expected pulses.
  logic [14:0]       mDiv   [NUM_CH];
  logic [14:0]       mSteps [NUM_CH];
  logic              mDir   [NUM_CH];
  logic              mPend  [NUM_CH];
  logic [NUM_CH-1:0] mLoad;
  logic              mErr, mDrop, mFail, mTo;
  logic [39:0]       frm;

  task automatic checkVal(input string tag, input logic [159:0] got, input logic [159:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clearPulses();
    mLoad = '0;
    mErr  = 1'b0;
    mDrop = 1'b0;
    mFail = 1'b0;
    mTo   = 1'b0;
  endtask

  task automatic modelReset();
    for (int c = 0; c < NUM_CH; c++) begin
      mDiv[c]   = '0;
      mSteps[c] = '0;
      mDir[c]   = 1'b0;
      mPend[c]  = 1'b0;
    end
    clearPulses();
  endtask

  task automatic modelFrame(input logic [39:0] f);
    int ch;
    ch = int'(f[3:0]);
    if (ch >= NUM_CH) begin
      mErr = 1'b1;
    end else if (mPend[ch]) begin
      mDrop = 1'b1;
    end else begin
      mDiv[ch]   = f[18:4];
      mSteps[ch] = f[33:19];
      mDir[ch]   = f[34];
      mLoad[ch]  = 1'b1;
      mPend[ch]  = (f[33:19] != 15'd0);
    end
  endtask

  task automatic modelComplete(input int ch);
    mPend[ch]  = 1'b0;
    mSteps[ch] = '0;
  endtask

  task automatic checkAll(input string tag);
    logic [15*NUM_CH-1:0] eDiv, eSteps;
    logic [NUM_CH-1:0]    eDir, ePend;
    for (int c = 0; c < NUM_CH; c++) begin
      eDiv[15*c +: 15]   = mDiv[c];
      eSteps[15*c +: 15] = mSteps[c];
      eDir[c]            = mDir[c];
      ePend[c]           = mPend[c];
    end
    checkVal({tag, ".div"},     160'(ch_divider), 160'(eDiv));
    checkVal({tag, ".steps"},   160'(ch_steps),   160'(eSteps));
    checkVal({tag, ".dir"},     160'(ch_dir),     160'(eDir));
    checkVal({tag, ".pending"}, 160'(pending),    160'(ePend));
    checkVal({tag, ".load"},    160'(ch_load),    160'(mLoad));
    checkVal({tag, ".err"},     160'(frame_err),  160'(mErr));
    checkVal({tag, ".drop"},    160'(frame_drop), 160'(mDrop));
    checkVal({tag, ".tmo"},     160'(rx_timeout), 160'(mTo));
    checkVal({tag, ".sfail"},   160'(start_fail), 160'(mFail));
  endtask

  function automatic logic [39:0] makeFrame(input logic [3:0] ch, input logic [14:0] div,
                                            input logic [14:0] steps, input logic dir);
    return {5'($urandom), dir, steps, div, ch};
  endfunction

  // Called at a falling edge; the byte is sampled on the next rising edge.
  task automatic sendByte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [39:0] f, input int maxGap);
    for (int i = 0; i < 5; i++) begin
      sendByte(f[8*i +: 8]);
      if (i < 4) repeat ($urandom_range(0, maxGap)) @(negedge CLK);
    end
  endtask

  task automatic dispatchCheck(input string tag, input logic [39:0] f);
    modelFrame(f);
    @(negedge CLK);
    checkAll(tag);
    clearPulses();
    @(negedge CLK);
    checkAll({tag, ".after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    ch_active = '0;
    modelReset();
    repeat (3) @(negedge CLK);
    checkAll("reset");
    rst_n = 1'b1;
    @(negedge CLK);

    frm = makeFrame(4'd3, 15'h00FF, 15'd6, 1'b1);
    sendFrame(frm, 0);
    dispatchCheck("ch3load", frm);
    ch_active[3] = 1'b1;
    repeat (5) @(negedge CLK);

    frm = makeFrame(4'd3, 15'h1234, 15'd77, 1'b0);
    sendFrame(frm, 1);
    dispatchCheck("ch3drop", frm);
    frm[3:0] = 4'd4;
    sendFrame(frm, 1);
    dispatchCheck("ch4load", frm);
    ch_active[4] = 1'b1;

    repeat (80) @(negedge CLK);
    ch_active[3] = 1'b0;
    @(negedge CLK);
    checkAll("ch3hold");
    @(negedge CLK);
    modelComplete(3);
    checkAll("ch3done");
    ch_active[4] = 1'b0;
    repeat (2) @(negedge CLK);
    modelComplete(4);
    checkAll("ch4done");

    frm = makeFrame(4'hC, 15'h0333, 15'd9, 1'b1);
    sendFrame(frm, 0);
    dispatchCheck("badch", frm);

    frm = makeFrame(4'd2, 15'h0111, 15'd5, 1'b0);
    for (int i = 0; i < 3; i++) sendByte(frm[8*i +: 8]);
    repeat (TIMEOUT_CYC - 1) @(negedge CLK);
    checkAll("toWait");
    @(negedge CLK);
    mTo = 1'b1;
    checkAll("toPulse");
    mTo = 1'b0;
    @(negedge CLK);
    checkAll("toPost");

    frm = makeFrame(4'd0, 15'h0ABC, 15'd1000, 1'b0);
    sendFrame(frm, 0);
    dispatchCheck("postTo", frm);
    repeat (START_WAIT - 2) @(negedge CLK);
    checkAll("sfWait");
    @(negedge CLK);
    mPend[0] = 1'b0;
    mFail    = 1'b1;
    checkAll("sfFire");
    mFail = 1'b0;
    @(negedge CLK);
    checkAll("sfPost");

    frm = makeFrame(4'd6, 15'h0042, 15'd0, 1'b1);
    sendFrame(frm, 1);
    dispatchCheck("zeroSteps", frm);

    frm = makeFrame(4'd5, 15'h0100, 15'd50, 1'b1);
    sendFrame(frm, 0);
    dispatchCheck("ch5load", frm);
    ch_active[5] = 1'b1;
    repeat (10) @(negedge CLK);
    frm = makeFrame(4'd5, 15'h0200, 15'd60, 1'b0);
    for (int i = 0; i < 4; i++) sendByte(frm[8*i +: 8]);
    ch_active[5] = 1'b0;
    sendByte(frm[39:32]);
    modelComplete(5);
    dispatchCheck("ch5same", frm);
    ch_active[5] = 1'b1;
    repeat (4) @(negedge CLK);

    frm = makeFrame(4'd7, 15'h0777, 15'd3, 1'b1);
    for (int i = 0; i < 2; i++) sendByte(frm[8*i +: 8]);
    rst_n     = 1'b0;
    ch_active = '0;
    modelReset();
    #1;
    checkAll("rstAsync");
    @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    frm = makeFrame(4'd9, 15'h5555, 15'h2AAA, 1'b1);
    sendFrame(frm, 2);
    dispatchCheck("postRst", frm);
    ch_active[9] = 1'b1;
    repeat (2) @(negedge CLK);

    for (int it = 0; it < 40; it++) begin
      logic [3:0] ch;
      logic       acc;
      int         pick;
      ch  = 4'($urandom_range(0, 11));
      frm = makeFrame(ch, 15'($urandom),
                      ($urandom_range(0, 3) == 0) ? 15'd0 : 15'($urandom_range(1, 32767)),
                      1'($urandom));
      sendFrame(frm, 2);
      dispatchCheck($sformatf("rnd%0d", it), frm);
      acc = (int'(ch) < NUM_CH) && mPend[int'(ch)] && !ch_active[int'(ch)];
      if (acc) ch_active[int'(ch)] = 1'b1;
      repeat (2) @(negedge CLK);
      pick = $urandom_range(0, NUM_CH - 1);
      if ($urandom_range(0, 1) == 1 && mPend[pick] && ch_active[pick]) begin
        ch_active[pick] = 1'b0;
        repeat (2) @(negedge CLK);
        modelComplete(pick);
        checkAll($sformatf("rndDone%0d", it));
      end
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/motor_cmd_dispatcher.md
# motor_cmd_dispatcher

Assembles 5-byte UART command frames and dispatches each to one of `NUM_CH` step/dir motor controllers. Each channel has a one-deep pending slot and a load/active handshake. It sits between the UART receiver's byte strobe and the `motorCtrlSimple_v2` array. It replaces ad-hoc per-channel loading with one sequenced, timeout-protected path, and exports `pending` for the status transmitter.

## Interface
Parameters:
- `NUM_CH`, 10: number of motor channels (≤16).
- `TIMEOUT_CYC`, 2400000: idle cycles after which a partial frame is discarded.
- `START_WAIT`, 16: cycles allowed for `ch_active` to rise after a load.

Ports:
- `CLK`  in  1  system clock (25 MHz).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte.
- `rx_data`  in  8  received byte.
- `ch_active`  in  NUM_CH  per-channel controller busy (high while stepping).
- `ch_divider`  out  15*NUM_CH  per-channel step-rate divider; channel c is at bits [15c+14:15c].
- `ch_steps`  out  15*NUM_CH  per-channel step count, packed the same way.
- `ch_dir`  out  NUM_CH  per-channel direction.
- `ch_load`  out  NUM_CH  one-cycle pulse: new command presented to the channel.
- `pending`  out  NUM_CH  channel holds an unfinished command.
- `frame_err`  out  1  pulse: complete frame with channel ≥ NUM_CH.
- `frame_drop`  out  1  pulse: valid frame rejected because the channel is pending.
- `rx_timeout`  out  1  pulse: partial frame discarded.
- `start_fail`  out  1  pulse: a loaded channel never went active.

## Operation
- Reset: all outputs 0, byte counter 0, timeout counter 0, all channels IDLE.
- Frame assembly:
  - Bytes arrive little-endian; each `rx_valid` shifts `rx_data` into the top byte of a 40-bit word and increments the byte count (0..4).
  - On the 5th byte the word is complete and the byte count returns to 0.
  - Field layout: [3:0] channel, [18:4] divider, [33:19] steps, [34] dir, [39:35] ignored.
- Timeout:
  - The timeout counter reloads to `TIMEOUT_CYC` on every `rx_valid`, then decrements to 0 and holds.
  - If byte count ≠ 0 and the counter reaches 0, the byte count clears and `rx_timeout` pulses once.
  - `rx_valid` in the expiry cycle takes priority: the byte is counted and the counter reloads.
- Dispatch of a complete frame:
  - channel ≥ NUM_CH: `frame_err` pulses; no channel changes.
  - Channel IDLE: latch divider/steps/dir into that channel's outputs and pulse `ch_load[c]`.
    - steps = 0: channel stays IDLE and `pending[c]` stays 0 (no-op load).
    - steps ≠ 0: channel goes to LOADED and `pending[c]` is set to 1.
  - Channel not IDLE: `frame_drop` pulses; outputs unchanged.
- Per-channel FSM, with NUM_CH independent instances:
  - IDLE → LOADED on accepted frame with steps ≠ 0.
  - LOADED → RUNNING when `ch_active[c]` = 1.
  - LOADED → IDLE after `START_WAIT` cycles with `ch_active[c]` = 0. `start_fail` pulses and `pending[c]` clears.
  - RUNNING → IDLE on the `ch_active[c]` falling edge. `pending[c]` clears and `ch_steps[c]` is zeroed; divider and dir are held.
  - `pending[c]` = 1 in LOADED and RUNNING.
- Simultaneous events:
  - A completion (RUNNING→IDLE) and a frame for the same channel in the same cycle: the completion is processed first and the frame is accepted (→ LOADED, load pulsed).
  - Different channels are fully independent.
- `rst_n` asserted mid-frame or mid-run clears everything asynchronously. Controllers see steps = 0 and `ch_load` = 0.

## Timing
- Dispatch latency:
  - 5th `rx_valid` sampled at edge N.
  - At edge N+1: `ch_divider`/`ch_steps`/`ch_dir`, `ch_load[c]` = 1 and `pending[c]` = 1, plus `frame_err`/`frame_drop` if applicable.
  - `ch_load` drops at N+2.
- Completion: `ch_active[c]` low is first sampled at edge M. At M+1, `pending[c]` = 0 and the channel accepts a frame completing at M.
- Start watchdog: starts counting at the `ch_load` edge. With `ch_active` still low, `start_fail` fires at load edge + `START_WAIT`.
- Timeout: the last byte is sampled at edge K. With no further bytes, `rx_timeout` is high for exactly one cycle, `TIMEOUT_CYC` cycles after K.
- All status pulses last exactly one cycle. A new frame can complete every 5 strobes; back-to-back strobes are allowed.

## Test plan
- Frame for ch 3 (div 0x00FF, steps 6, dir 1): `ch_load[3]` at N+1, field values correct, `pending[3]` = 1. Raise `ch_active[3]` for 100 cycles, then drop it → `pending[3]` = 0 one cycle later and `ch_steps[3]` = 0.
- Second frame to ch 3 while RUNNING → `frame_drop` pulse and ch 3 outputs unchanged. Same frame to ch 4 → accepted.
- Channel byte 0x0C → `frame_err`; no `ch_load`, all `pending` = 0.
- Send 3 bytes, then idle (TIMEOUT_CYC = 100 in the bench) → `rx_timeout` 100 cycles after the last byte. A following full 5-byte frame decodes correctly.
- Load ch 0 and hold `ch_active[0]` = 0 → `start_fail` at load + 16 and `pending[0]` clears. A steps = 0 frame → `ch_load` pulse, `pending` stays 0.
- Frame completing the same cycle as `ch_active[5]` falls → accepted. Assert `rst_n` mid-frame → all outputs 0 and the next full frame decodes correctly.
